// File: rtl/boot_loader.sv
// Program-memory loader for the J1: parses a framed UART byte stream, writes
// little-endian 16-bit words from address 0 and releases the CPU on a good checksum.
module boot_loader #(
  parameter int unsigned size       = 'h1000,
  parameter int unsigned addr_width = $clog2(size)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [addr_width-1:0] mem_address,
  output logic [15:0]           mem_data,
  output logic                  mem_wren,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] SYNC    = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] LEN_HI  = 3'd2;
  localparam logic [2:0] DATA_LO = 3'd3;
  localparam logic [2:0] DATA_HI = 3'd4;
  localparam logic [2:0] CHECK   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERROR   = 3'd7;

  logic [2:0]            state;
  logic [7:0]            len_lo;
  logic [7:0]            low_byte;
  logic [7:0]            sum;
  logic [addr_width-1:0] word_addr;
  logic [addr_width-1:0] last_word;

  logic        take;
  logic [15:0] len;
  logic [7:0]  sum_next;
  logic        len_big;

  assign rx_ready = (state != DONE) && (state != ERROR);

  always_comb begin
    take     = rx_valid && rx_ready;
    len      = {rx_data, len_lo};
    sum_next = sum + rx_data;
    len_big  = {16'h0000, len} > 32'(size);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      len_lo      <= '0;
      low_byte    <= '0;
      sum         <= '0;
      word_addr   <= '0;
      last_word   <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (take) begin
        case (state)
          SYNC: begin
            if (rx_data == 8'hA5) begin
              state     <= LEN_LO;
              sum       <= '0;
              word_addr <= '0;
            end
          end
          LEN_LO: begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
          LEN_HI: begin
            if (len == '0) begin
              state <= CHECK;
            end else if (len_big) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              // Store the final word index so the DATA_HI test needs no wide compare
              last_word <= addr_width'(len - 16'd1);
              state     <= DATA_LO;
            end
          end
          DATA_LO: begin
            low_byte <= rx_data;
            sum      <= sum_next;
            state    <= DATA_HI;
          end
          DATA_HI: begin
            sum         <= sum_next;
            mem_address <= word_addr;
            mem_data    <= {rx_data, low_byte};
            mem_wren    <= 1'b1;
            word_addr   <= word_addr + 1'b1;
            state       <= (word_addr == last_word) ? CHECK : DATA_LO;
          end
          CHECK: begin
            if (sum_next == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized self-checking bench for boot_loader against a frame-parsing model.
module tb_boot_loader;
  localparam int SIZE = 'h1000;
  localparam int AW   = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] mem_address;
  logic [15:0]   mem_data;
  logic          mem_wren;
  logic          cpu_reset;
  logic          done;
  logic          error;

  boot_loader #(.size(SIZE), .addr_width(AW)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int accepted;
  int exp_outcome;  // 0 incomplete, 1 good load, 2 failed load
  int exp_used;
  logic [7:0]      stim_q[$];
  logic [AW+15:0]  wr_q[$];
  logic [AW+15:0]  exp_q[$];

  always @(negedge clock) if (mem_wren === 1'b1) wr_q.push_back({mem_address, mem_data});

  // Parses the byte list the way a frame is defined, independent of any state machine.
  function automatic void model();
    int i, n, s, nb;
    nb = stim_q.size();
    exp_q.delete(); exp_outcome = 0; exp_used = nb; i = 0; s = 0;
    while (i < nb && stim_q[i] != 8'hA5) i++;
    if (i + 3 > nb) return;
    n = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
    i += 3;
    if (n > SIZE) begin exp_outcome = 2; exp_used = i; return; end
    for (int k = 0; k < n; k++) begin
      if (i + 2 > nb) return;
      exp_q.push_back({AW'(k), stim_q[i+1], stim_q[i]});
      s += int'(stim_q[i]) + int'(stim_q[i+1]);
      i += 2;
    end
    if (i >= nb) return;
    exp_outcome = ((s + int'(stim_q[i])) % 256 == 0) ? 1 : 2;
    exp_used = i + 1;
  endfunction

  task automatic drive(input int gap_pct);
    int tries; bit took; bit stuck;
    accepted = 0; stuck = 0;
    foreach (stim_q[i]) begin
      if (!stuck) begin
        took = 0; tries = 0;
        while (!took && tries < 6) begin
          if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            rx_valid = 1'b0; rx_data = 8'($urandom);
          end else begin
            rx_valid = 1'b1; rx_data = stim_q[i]; took = rx_ready; tries++;
          end
          @(posedge clock); @(negedge clock);
        end
        if (took) accepted++; else stuck = 1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    wr_q.delete();
  endtask

  task automatic load_basic(input logic [7:0] ck);
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, ck};
  endtask

  task automatic test_reset();
    reset = 1'b1; @(negedge clock);
    checks++; if ({rx_ready, mem_wren, cpu_reset, done, error} !== 5'b10100) begin errors++;
      $display("FAIL reset_flags: got %b expected 10100", {rx_ready, mem_wren, cpu_reset, done, error}); end
    checks++; if ({mem_address, mem_data} !== '0) begin errors++;
      $display("FAIL reset_mem: got %h/%h expected 0/0", mem_address, mem_data); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    load_basic(8'h42);
    stim_q.pop_back();
    drive(0);
    checks++; if ({done, cpu_reset} !== 2'b01) begin errors++;
      $display("FAIL basic_pre_ck: done/cpu_reset got %b expected 01", {done, cpu_reset}); end
    stim_q = '{8'h42};
    drive(0);
    checks++; if ({done, cpu_reset, error, rx_ready} !== 4'b1000) begin errors++;
      $display("FAIL basic_done: done/cpu_reset/error/rx_ready got %b expected 1000", {done, cpu_reset, error, rx_ready}); end
    #1;
    checks++; if (wr_q.size() != 2 || wr_q[0] !== {12'h000, 16'h1234} || wr_q[1] !== {12'h001, 16'hABCD}) begin
      errors++; $display("FAIL basic_writes: got %p expected '{0001234,001ABCD}", wr_q); end
  endtask

  task automatic test_prefix_gaps();
    do_reset();
    load_basic(8'h42);
    stim_q.push_front(8'h5A); stim_q.push_front(8'hFF); stim_q.push_front(8'h00);
    drive(40);
    #1;
    checks++; if (wr_q.size() != 2 || wr_q[0] !== {12'h000, 16'h1234} || wr_q[1] !== {12'h001, 16'hABCD}) begin
      errors++; $display("FAIL prefix_writes: got %p expected '{0001234,001ABCD}", wr_q); end
    checks++; if ({done, cpu_reset} !== 2'b10) begin errors++;
      $display("FAIL prefix_done: done/cpu_reset got %b expected 10", {done, cpu_reset}); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_basic(8'h43);
    drive(0);
    checks++; if ({error, cpu_reset, done, rx_ready} !== 4'b1100) begin errors++;
      $display("FAIL badck_flags: error/cpu_reset/done/rx_ready got %b expected 1100", {error, cpu_reset, done, rx_ready}); end
    #1;
    checks++; if (wr_q.size() != 2) begin errors++;
      $display("FAIL badck_writes: got %0d writes expected 2", wr_q.size()); end
    stim_q = '{8'hA5, 8'h01, 8'h00};
    drive(0);
    checks++; if (accepted != 0 || wr_q.size() != 2) begin errors++;
      $display("FAIL badck_locked: accepted %0d writes %0d expected 0 and 2", accepted, wr_q.size()); end
  endtask

  task automatic test_zero_len();
    do_reset();
    stim_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    drive(0);
    #1;
    checks++; if ({done, cpu_reset, error} !== 3'b100 || wr_q.size() != 0) begin errors++;
      $display("FAIL zero_len: done/cpu_reset/error got %b writes %0d expected 100 and 0", {done, cpu_reset, error}, wr_q.size()); end
  endtask

  task automatic test_too_long();
    do_reset();
    stim_q = '{8'hA5, 8'h01, 8'h10};
    drive(0);
    checks++; if ({error, rx_ready, done, cpu_reset} !== 4'b1001) begin errors++;
      $display("FAIL too_long: error/rx_ready/done/cpu_reset got %b expected 1001", {error, rx_ready, done, cpu_reset}); end
    repeat (3) @(negedge clock);
    checks++; if (wr_q.size() != 0) begin errors++;
      $display("FAIL too_long_writes: got %0d expected 0", wr_q.size()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    stim_q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12};
    drive(0);
    checks++; if (mem_wren !== 1'b1) begin errors++;
      $display("FAIL midrst_wren: got %b expected 1", mem_wren); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({rx_ready, mem_wren, cpu_reset, done, error} !== 5'b10100 || {mem_address, mem_data} !== '0) begin
      errors++; $display("FAIL midrst_values: flags %b addr %h data %h expected 10100/0/0",
        {rx_ready, mem_wren, cpu_reset, done, error}, mem_address, mem_data); end
    @(negedge clock); reset = 1'b0; wr_q.delete();
    load_basic(8'h42);
    drive(0);
    #1;
    checks++; if (done !== 1'b1 || wr_q.size() != 2 || wr_q[0] !== {12'h000, 16'h1234} || wr_q[1] !== {12'h001, 16'hABCD}) begin
      errors++; $display("FAIL midrst_reload: done %b writes %p", done, wr_q); end
  endtask

  task automatic test_random_frames();
    int n, s; logic [7:0] b;
    for (int t = 0; t < 12; t++) begin
      do_reset();
      stim_q.delete();
      repeat ($urandom_range(0, 3)) begin b = 8'($urandom); stim_q.push_back(b == 8'hA5 ? 8'h00 : b); end
      n = $urandom_range(0, 7); s = 0;
      stim_q.push_back(8'hA5); stim_q.push_back(8'(n)); stim_q.push_back(8'h00);
      repeat (2 * n) begin b = 8'($urandom); s += int'(b); stim_q.push_back(b); end
      stim_q.push_back(8'((256 - s % 256) + (($urandom_range(0, 2) == 0) ? 1 : 0)));
      model();
      drive($urandom_range(0, 50));
      #1;
      checks++; if ({done, error, cpu_reset, rx_ready} !== {exp_outcome == 1, exp_outcome == 2, exp_outcome != 1, exp_outcome == 0}) begin
        errors++; $display("FAIL rand_flags[%0d]: done/error/cpu_reset/rx_ready got %b expected outcome %0d", t, {done, error, cpu_reset, rx_ready}, exp_outcome); end
      checks++; if (accepted != exp_used || wr_q != exp_q) begin errors++;
        $display("FAIL rand_writes[%0d]: accepted %0d/%0d writes %p expected %p", t, accepted, exp_used, wr_q, exp_q); end
    end
  endtask

  task automatic test_full_size();
    int s; logic [7:0] b;
    do_reset();
    stim_q = '{8'hA5, 8'h00, 8'h10};
    s = 0;
    repeat (2 * SIZE) begin b = 8'($urandom); s += int'(b); stim_q.push_back(b); end
    stim_q.push_back(8'(256 - s % 256));
    model();
    drive(0);
    #1;
    checks++; if ({done, error} !== {exp_outcome == 1, exp_outcome == 2} || exp_outcome != 1) begin errors++;
      $display("FAIL full_flags: done/error got %b model outcome %0d expected done", {done, error}, exp_outcome); end
    checks++; if (wr_q.size() != SIZE || wr_q != exp_q) begin errors++;
      $display("FAIL full_writes: got %0d writes expected %0d (or data differs)", wr_q.size(), exp_q.size()); end
    checks++; if (wr_q.size() > 0 && wr_q[wr_q.size()-1][AW+15:16] !== 12'hFFF) begin errors++;
      $display("FAIL full_last_addr: got %h expected fff", wr_q[wr_q.size()-1][AW+15:16]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix_gaps();
    test_bad_checksum();
    test_zero_len();
    test_too_long();
    test_mid_reset();
    test_random_frames();
    test_full_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
